// File: rtl/bmem_types.sv
// Shared beat/line types and FSM encoding for the 4-beat x 64-bit burst memory responder.
package bmem_types;
   localparam int BMEM_BEATS  = 4;
   localparam int BMEM_BEAT_W = 64;
   localparam int BMEM_LINE_W = BMEM_BEATS * BMEM_BEAT_W;

   typedef logic [BMEM_BEAT_W-1:0] bmem_beat_t;
   typedef logic [BMEM_LINE_W-1:0] bmem_line_t;

   typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} bmem_state_t;

   // Beat 0 occupies the least significant 64 bits of a line.
   function automatic bmem_beat_t line_beat(input bmem_line_t line, input logic [1:0] beat);
      return line[BMEM_BEAT_W*beat +: BMEM_BEAT_W];
   endfunction
endpackage

// File: rtl/burst_mem_responder_if.sv
// bmem_* burst bus bundle; the host drives the master side, the responder the slave side.
interface burst_mem_responder_if;
   import bmem_types::*;

   logic [31:0] address;
   logic        read;
   logic        write;
   bmem_beat_t  wdata;
   bmem_beat_t  rdata;
   logic        resp;

   modport master (output address, read, write, wdata, input rdata, resp);
   modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/bmem_line_store.sv
// Single-port 256-bit line store: synchronous write, registered synchronous read.
module bmem_line_store
   import bmem_types::*;
#(
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] addr,
   input  logic             we,
   input  bmem_line_t       wdata,
   input  logic             re,
   output bmem_line_t       rdata
);
   bmem_line_t mem_q [2**IDX_W];
   bmem_line_t rdata_q;

   // The read register only reloads on re, so it doubles as the burst snapshot.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the bmem 4-beat burst bus with programmable first-beat latency.
// Define BMEM_OPEN_ROW_EN to shorten latency to LATENCY_HIT when the request hits the last row.
module burst_mem_responder
   import bmem_types::*;
#(
   parameter int LINE_IDX_W = 8,
   parameter int LATENCY    = 10
`ifdef BMEM_OPEN_ROW_EN
   , parameter int LATENCY_HIT = 3,
   parameter int ROW_SHIFT   = 10
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   burst_mem_responder_if.slave bus,
   output logic                 prot_err
);
   localparam int LAT_W = $clog2(LATENCY + 1);

   bmem_state_t                    state_q, state_d;
   logic [LAT_W-1:0]               lat_cnt_q, lat_cnt_d;
   logic [1:0]                     beat_q, beat_d;
   logic [LINE_IDX_W-1:0]          idx_q, idx_d;
   logic                           is_write_q, is_write_d;
   logic                           prot_err_q, prot_err_d;
   logic [3*BMEM_BEAT_W-1:0]       staging_q, staging_d;

   logic                  req;
   logic [LINE_IDX_W-1:0] bus_idx;
   logic [LAT_W-1:0]      first_lat;
   logic [LINE_IDX_W-1:0] ram_addr;
   logic                  ram_we;
   logic                  ram_re;
   bmem_line_t            ram_wdata;
   bmem_line_t            snap_line;
   logic                  unused_addr_bits;

   assign req              = bus.read | bus.write;
   assign bus_idx          = bus.address[5 +: LINE_IDX_W];
   assign unused_addr_bits = ^{bus.address[31:5+LINE_IDX_W], bus.address[4:0]};
   assign prot_err         = prot_err_q;

`ifdef BMEM_OPEN_ROW_EN
   localparam int ROW_W = 32 - ROW_SHIFT;

   logic [ROW_W-1:0] row_q, row_d;
   logic             row_valid_q, row_valid_d;
   logic             row_hit;

   assign row_hit   = row_valid_q && (row_q == bus.address[31:ROW_SHIFT]);
   assign first_lat = row_hit ? LAT_W'(LATENCY_HIT) : LAT_W'(LATENCY);

   always_comb begin
      row_d       = row_q;
      row_valid_d = row_valid_q;
      if (state_q == IDLE && req) begin
         row_d       = bus.address[31:ROW_SHIFT];
         row_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q       <= '0;
         row_valid_q <= 1'b0;
      end else begin
         row_q       <= row_d;
         row_valid_q <= row_valid_d;
      end
   end
`else
   assign first_lat = LAT_W'(LATENCY);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A one-cycle latency skips WAIT entirely; the snapshot is then read on the accept edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = (first_lat == LAT_W'(1)) ? BURST : WAIT;
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (lat_cnt_q == LAT_W'(1)) begin
               state_d = BURST;
            end
         end
         BURST:   if (beat_q == 2'd3) state_d = RECOVER;
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lat_cnt_d  = lat_cnt_q;
      beat_d     = beat_q;
      idx_d      = idx_q;
      is_write_d = is_write_q;
      prot_err_d = prot_err_q;
      staging_d  = staging_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d      = bus_idx;
               is_write_d = bus.write;
               lat_cnt_d  = first_lat - LAT_W'(1);
               beat_d     = 2'd0;
               if (bus.read && bus.write) prot_err_d = 1'b1;
            end
         end
         WAIT:  lat_cnt_d = lat_cnt_q - LAT_W'(1);
         BURST: begin
            beat_d = beat_q + 2'd1;
            for (int b = 0; b < BMEM_BEATS - 1; b++) begin
               if (is_write_q && beat_q == b[1:0]) begin
                  staging_d[b*BMEM_BEAT_W +: BMEM_BEAT_W] = bus.wdata;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt_q  <= '0;
         beat_q     <= '0;
         idx_q      <= '0;
         is_write_q <= 1'b0;
         prot_err_q <= 1'b0;
         staging_q  <= '0;
      end else begin
         lat_cnt_q  <= lat_cnt_d;
         beat_q     <= beat_d;
         idx_q      <= idx_d;
         is_write_q <= is_write_d;
         prot_err_q <= prot_err_d;
         staging_q  <= staging_d;
      end
   end

   // The last write beat goes straight from the bus into the line commit.
   always_comb begin
      bus.resp  = (state_q == BURST);
      bus.rdata = '0;
      if (state_q == BURST && !is_write_q) bus.rdata = line_beat(snap_line, beat_q);
      ram_addr  = (state_q == IDLE) ? bus_idx : idx_q;
      ram_re    = ((state_q == IDLE) && req && (first_lat == LAT_W'(1))) ||
                  ((state_q == WAIT) && req && (lat_cnt_q == LAT_W'(1)));
      ram_we    = (state_q == BURST) && is_write_q && (beat_q == 2'd3);
      ram_wdata = {bus.wdata, staging_q};
   end

   bmem_line_store #(.IDX_W(LINE_IDX_W)) u_store (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .re    (ram_re),
      .rdata (snap_line)
   );
endmodule
